sw_ctrl_fsm: RTL and testbench

Stopwatch front-end control stage. It sits directly upstream of the minute and second counters and drives their i_Sw_Clk, i_Start_Stop, i_reset and lowest-stage i_ena inputs. It debounces the raw start/stop and reset buttons and runs an IDLE/RUN/PAUSE state machine. It also generates the base count tick from a prescaler that freezes while paused.

---
 rtl/sw_ctrl_fsm.sv | 113 +++++++++++
 tb/tb_sw_ctrl_fsm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_ctrl_fsm.sv
// Stopwatch front-end control: button synchronise/debounce, IDLE/RUN/PAUSE FSM,
// and a base-tick prescaler that freezes while paused.
module sw_ctrl_fsm #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_start,
  input  logic       i_btn_reset,
  output logic       o_Sw_Clk,
  output logic       o_Start_Stop,
  output logic       o_reset,
  output logic       o_tick,
  output logic [1:0] o_state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RUN     = 2'b01;
  localparam logic [1:0] S_PAUSE   = 2'b10;
  localparam logic [1:0] S_ILLEGAL = 2'b11;

  // Bit 0 carries the start/stop button, bit 1 the reset button.
  logic [1:0]    btn;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    press;
  logic [DW-1:0] deb_cnt [2];

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          stay_run;
  logic [PW-1:0] presc;

  assign btn     = {i_btn_reset, i_btn_start};
  assign o_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Reset press outranks a simultaneous start press.
  always_comb begin
    state_nxt = state;
    if (state == S_ILLEGAL) begin
      state_nxt = S_IDLE;
    end else if (press[1]) begin
      state_nxt = S_IDLE;
    end else if (press[0]) begin
      case (state)
        S_IDLE:  state_nxt = S_RUN;
        S_RUN:   state_nxt = S_PAUSE;
        S_PAUSE: state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
    stay_run = (state == S_RUN) && (state_nxt == S_RUN);
  end

  // The prescaler only advances on cycles that stay in RUN, so a pause landing
  // on a wrap keeps the pending tick for the resumed period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      presc        <= '0;
      o_Sw_Clk     <= 1'b0;
      o_Start_Stop <= 1'b0;
      o_reset      <= 1'b0;
      o_tick       <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_Sw_Clk     <= (state_nxt == S_RUN);
      o_Start_Stop <= (state_nxt == S_RUN);
      o_reset      <= press[1];
      o_tick       <= stay_run && (presc == PRESC_MAX);
      if (state_nxt == S_IDLE) begin
        presc <= '0;
      end else if (stay_run) begin
        presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sw_ctrl_fsm.sv
// Self-checking bench for sw_ctrl_fsm: cycle scoreboard against a behavioural
// model plus directed latency/tick-spacing checks.
module tb_sw_ctrl_fsm;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_btn_start = 1'b0;
  logic       i_btn_reset = 1'b0;
  logic       o_Sw_Clk;
  logic       o_Start_Stop;
  logic       o_reset;
  logic       o_tick;
  logic [1:0] o_state;

  sw_ctrl_fsm #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_btn_start  (i_btn_start),
    .i_btn_reset  (i_btn_reset),
    .o_Sw_Clk     (o_Sw_Clk),
    .o_Start_Stop (o_Start_Stop),
    .o_reset      (o_reset),
    .o_tick       (o_tick),
    .o_state      (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // behavioural model
  logic [1:0] m_s1, m_s2, m_deb, m_deb_d, m_press, m_state;
  int         m_run_len [2];
  int         m_presc;
  logic       m_rst_o, m_run_o, m_tick;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_d = '0; m_press = '0;
    m_state = IDLE; m_presc = 0;
    m_run_len[0] = 0; m_run_len[1] = 0;
    m_rst_o = 1'b0; m_run_o = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] b);
    logic [1:0] nxt;
    logic       stay;
    if (m_state == 2'b11)   nxt = IDLE;
    else if (m_press[1])    nxt = IDLE;
    else if (m_press[0])    nxt = (m_state == RUN) ? PAUSE : RUN;
    else                    nxt = m_state;
    stay    = (m_state == RUN) && (nxt == RUN);
    m_tick  = stay && (m_presc == TD - 1);
    if (nxt == IDLE) m_presc = 0;
    else if (stay)   m_presc = (m_presc + 1) % TD;
    m_rst_o = m_press[1];
    m_run_o = (nxt == RUN);
    m_state = nxt;
    m_press = m_deb & ~m_deb_d;
    m_deb_d = m_deb;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run_len[i]++;
        if (m_run_len[i] == DB) begin
          m_deb[i] = ~m_deb[i];
          m_run_len[i] = 0;
        end
      end else begin
        m_run_len[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  // monitor state
  int         cyc = 0;
  int         ss_rise_cyc = 0;
  int         last_st_cyc = 0;
  int         st_changes = 0;
  int         rst_pulses = 0;
  int         bad_ticks = 0;
  int         any_out = 0;
  logic       pause_seen = 1'b0;
  logic       prev_ss = 1'b0;
  logic [1:0] prev_state = 2'b00;
  int         tick_q[$];

  // driver: one clock per call, inputs applied on the falling edge
  task automatic cycle(input logic s, input logic r);
    logic [5:0] e;
    logic [5:0] obs;
    i_btn_start = s;
    i_btn_reset = r;
    @(posedge clk);
    cyc++;
    if (!rst) model_reset();
    else      model_step({r, s});
    exp_q.push_back({m_state, m_run_o, m_run_o, m_rst_o, m_tick});
    @(negedge clk);
    obs = {o_state, o_Sw_Clk, o_Start_Stop, o_reset, o_tick};
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("outputs", {26'd0, obs}, {26'd0, e});
    end
    if (o_Start_Stop && !prev_ss) ss_rise_cyc = cyc;
    if (o_tick) tick_q.push_back(cyc);
    if (o_tick && o_state != RUN) bad_ticks++;
    if (o_state != prev_state) begin
      st_changes++;
      last_st_cyc = cyc;
    end
    if (o_reset) rst_pulses++;
    if (o_state == PAUSE) pause_seen = 1'b1;
    if (obs != 6'd0) any_out++;
    prev_ss    = o_Start_Stop;
    prev_state = o_state;
  endtask

  int raw_cyc;
  int k;

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("reset_vals", {27'd0, o_state, o_Sw_Clk, o_Start_Stop, o_reset, o_tick}, 32'd0);
    repeat (3) cycle(1'b0, 1'b0);
    rst = 1'b1;

    // 1: idle after reset release
    any_out = 0; st_changes = 0;
    repeat (50) cycle(1'b0, 1'b0);
    chk("idle_quiet", any_out, 0);
    chk("idle_no_change", st_changes, 0);

    // 2: clean start press; edges counted include the one that samples the raw edge
    tick_q.delete(); st_changes = 0;
    raw_cyc = cyc + 1;
    repeat (20) cycle(1'b1, 1'b0);
    chk("start_latency", ss_rise_cyc - raw_cyc + 1, 7);
    chk("start_state", o_state, RUN);
    chk("tick_count", tick_q.size() >= 3, 1);
    if (tick_q.size() >= 3) begin
      chk("tick1", tick_q[0] - ss_rise_cyc, 4);
      chk("tick2", tick_q[1] - ss_rise_cyc, 8);
      chk("tick3", tick_q[2] - ss_rise_cyc, 12);
    end
    repeat (15) cycle(1'b0, 1'b0);
    chk("release_no_change", st_changes, 1);

    // 3: back to IDLE, then glitch and bounce on start
    rst_pulses = 0;
    repeat (8) cycle(1'b0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0);
    chk("rstbtn_idle", o_state, IDLE);
    chk("rstbtn_pulses", rst_pulses, 1);
    st_changes = 0;
    repeat (2) cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    chk("glitch_ignored", st_changes, 0);
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int i = 5; i >= 0; i--) cycle(pat[i], 1'b0);
    end
    repeat (12) cycle(1'b1, 1'b0);
    chk("bounce_one_change", st_changes, 1);
    chk("bounce_run", o_state, RUN);
    repeat (10) cycle(1'b0, 1'b0);

    // 4: pause two cycles into a period, hold, resume
    k = 0;
    while (m_presc != 0 && k < 20) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    chk("pause_align", m_presc, 0);
    bad_ticks = 0;
    repeat (4) cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    chk("paused", o_state, PAUSE);
    tick_q.delete();
    repeat (4) cycle(1'b1, 1'b0);
    repeat (16) cycle(1'b0, 1'b0);
    chk("resumed", o_state, RUN);
    chk("no_tick_in_pause", bad_ticks, 0);
    chk("resume_ticks", tick_q.size() >= 2, 1);
    if (tick_q.size() >= 2) begin
      chk("resume_tick1", tick_q[0] - last_st_cyc, 2);
      chk("resume_tick2", tick_q[1] - tick_q[0], 4);
    end

    // 5: simultaneous start and reset press
    rst_pulses = 0; pause_seen = 1'b0;
    repeat (4) cycle(1'b1, 1'b1);
    repeat (12) cycle(1'b0, 1'b0);
    chk("both_idle", o_state, IDLE);
    chk("both_rst_pulse", rst_pulses, 1);
    chk("both_no_pause", pause_seen, 0);
    chk("both_ss_low", o_Start_Stop, 0);

    // 6: async reset mid-period with start held
    repeat (4) cycle(1'b1, 1'b0);
    repeat (9) cycle(1'b0, 1'b0);
    chk("pre_reset_run", o_state, RUN);
    repeat (2) cycle(1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_reset", {27'd0, o_state, o_Sw_Clk, o_Start_Stop, o_reset, o_tick}, 32'd0);
    model_reset();
    repeat (3) cycle(1'b1, 1'b0);
    rst = 1'b1;
    st_changes = 0; tick_q.delete();
    raw_cyc = cyc + 1;
    repeat (20) cycle(1'b1, 1'b0);
    chk("rerun_latency", ss_rise_cyc - raw_cyc + 1, 7);
    chk("rerun_once", st_changes, 1);
    chk("rerun_state", o_state, RUN);
    chk("rerun_tick", tick_q.size() >= 1, 1);
    if (tick_q.size() >= 1) chk("rerun_tick1", tick_q[0] - ss_rise_cyc, 4);
    repeat (10) cycle(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
